// File: rtl/mouse_cell_selector.sv
// mouse_cell_selector: maps the mouse cursor onto a 3x3 board and turns a
// left-button press/release inside one cell into a single pending click.
//
// click handshake: click_valid is held high with a stable click_cell while
// the FSM is in PEND; the click is consumed on the first rising clk edge at
// which click_ack is high, after which click_valid drops. click_ack has no
// effect while click_valid is low.
module mouse_cell_selector #(
    parameter int BOARD_X0 = 170,
    parameter int BOARD_Y0 = 90,
    parameter int CELL_W   = 100,
    parameter int CELL_H   = 100,
    parameter int HOLD_MAX = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] posX,
    input  logic [8:0] posY,
    input  logic [2:0] buttons,
    input  logic       click_ack,
    output logic [3:0] hover_cell,
    output logic [3:0] click_cell,
    output logic       click_valid,
    output logic       busy
);

    // Hold counter is at least 26 bits, wider only if HOLD_MAX needs it.
    localparam int CNT_W = ($clog2(HOLD_MAX + 1) > 26) ? $clog2(HOLD_MAX + 1) : 26;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    // Cell boundaries in 11-bit unsigned arithmetic so no bound wraps.
    localparam logic [10:0] X_B0 = 11'(BOARD_X0);
    localparam logic [10:0] X_B1 = 11'(BOARD_X0 + CELL_W);
    localparam logic [10:0] X_B2 = 11'(BOARD_X0 + 2 * CELL_W);
    localparam logic [10:0] X_B3 = 11'(BOARD_X0 + 3 * CELL_W);
    localparam logic [10:0] Y_B0 = 11'(BOARD_Y0);
    localparam logic [10:0] Y_B1 = 11'(BOARD_Y0 + CELL_H);
    localparam logic [10:0] Y_B2 = 11'(BOARD_Y0 + 2 * CELL_H);
    localparam logic [10:0] Y_B3 = 11'(BOARD_Y0 + 3 * CELL_H);

    localparam logic [3:0] NO_CELL = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        ABORT = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [3:0]       press_cell, press_cell_next;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_next;

    logic [10:0] x_ext, y_ext;
    logic [1:0]  col, row;
    logic        col_ok, row_ok;
    logic [3:0]  hover_next;
    logic [3:0]  hover_q;
    logic        left_q, left_d, rise_q, fall_q;

    // Right and middle buttons play no part in selection.
    logic unused_buttons;
    assign unused_buttons = ^buttons[2:1];

    assign x_ext = {1'b0, posX};
    assign y_ext = {2'b00, posY};

    // Comparator-based cell lookup; low edge inclusive, high edge exclusive.
    always_comb begin
        col    = 2'd0;
        row    = 2'd0;
        col_ok = 1'b0;
        row_ok = 1'b0;
        if (x_ext >= X_B0 && x_ext < X_B1) begin
            col = 2'd0; col_ok = 1'b1;
        end else if (x_ext >= X_B1 && x_ext < X_B2) begin
            col = 2'd1; col_ok = 1'b1;
        end else if (x_ext >= X_B2 && x_ext < X_B3) begin
            col = 2'd2; col_ok = 1'b1;
        end
        if (y_ext >= Y_B0 && y_ext < Y_B1) begin
            row = 2'd0; row_ok = 1'b1;
        end else if (y_ext >= Y_B1 && y_ext < Y_B2) begin
            row = 2'd1; row_ok = 1'b1;
        end else if (y_ext >= Y_B2 && y_ext < Y_B3) begin
            row = 2'd2; row_ok = 1'b1;
        end
        hover_next = (col_ok && row_ok) ? ({2'b00, row} * 4'd3 + {2'b00, col}) : NO_CELL;
    end

    // Register hover cell, the left button, and its registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            hover_q <= NO_CELL;
            left_q  <= 1'b0;
            left_d  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            hover_q <= hover_next;
            left_q  <= buttons[0];
            left_d  <= left_q;
            rise_q  <= left_q & ~left_d;
            fall_q  <= ~left_q & left_d;
        end
    end

    // FSM state, latched press cell and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            press_cell <= NO_CELL;
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            press_cell <= press_cell_next;
            hold_cnt   <= hold_cnt_next;
        end
    end

    // Next-state logic: release beats timeout, timeout beats cell change.
    always_comb begin
        state_next      = state;
        press_cell_next = press_cell;
        hold_cnt_next   = hold_cnt;
        case (state)
            IDLE: begin
                if (rise_q) begin
                    if (hover_q != NO_CELL) begin
                        press_cell_next = hover_q;
                        hold_cnt_next   = '0;
                        state_next      = PRESS;
                    end else begin
                        state_next = ABORT;
                    end
                end
            end
            PRESS: begin
                if (hold_cnt != CNT_SAT) hold_cnt_next = hold_cnt + 1'b1;
                if (fall_q) begin
                    state_next = (hover_q == press_cell) ? PEND : IDLE;
                end else if (hold_cnt >= CNT_LAST) begin
                    state_next = ABORT;
                end else if (hover_q != press_cell) begin
                    state_next = ABORT;
                end
            end
            ABORT: begin
                if (fall_q) state_next = IDLE;
            end
            PEND: begin
                if (click_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign hover_cell  = hover_q;
    assign click_valid = (state == PEND);
    assign click_cell  = (state == PEND) ? press_cell : NO_CELL;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mouse_cell_selector.sv
// Directed bench for mouse_cell_selector: a table of cursor positions with
// hand-computed hover cells, then hand-written press/release sequences.
module tb_mouse_cell_selector;

  logic       clk;
  logic       reset;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] buttons;
  logic       click_ack;
  logic [3:0] hover_cell;
  logic [3:0] click_cell;
  logic       click_valid;
  logic       busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] exp_cell;
  } hov_vec_t;

  hov_vec_t vecs[16];

  mouse_cell_selector #(
    .BOARD_X0(170), .BOARD_Y0(90), .CELL_W(100), .CELL_H(100), .HOLD_MAX(16)
  ) dut (
    .clk(clk), .reset(reset), .posX(posX), .posY(posY), .buttons(buttons),
    .click_ack(click_ack), .hover_cell(hover_cell), .click_cell(click_cell),
    .click_valid(click_valid), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_pos(input int x, input int y);
    posX = 10'(x);
    posY = 9'(y);
  endtask

  // press at the current position, hold for hold_cycles, release, wait 3 edges
  task automatic press_release(input int hold_cycles);
    buttons = 3'b001;
    tick(hold_cycles);
    buttons = 3'b000;
    tick(3);
  endtask

  initial begin
    logic saw_valid;
    logic bad;

    vecs[0]  = '{10'd175,  9'd95,  4'd0};
    vecs[1]  = '{10'd469,  9'd389, 4'd8};
    vecs[2]  = '{10'd470,  9'd389, 4'd15};
    vecs[3]  = '{10'd270,  9'd90,  4'd1};
    vecs[4]  = '{10'd269,  9'd90,  4'd0};
    vecs[5]  = '{10'd170,  9'd90,  4'd0};
    vecs[6]  = '{10'd169,  9'd90,  4'd15};
    vecs[7]  = '{10'd170,  9'd89,  4'd15};
    vecs[8]  = '{10'd370,  9'd290, 4'd8};
    vecs[9]  = '{10'd275,  9'd195, 4'd4};
    vecs[10] = '{10'd375,  9'd195, 4'd5};
    vecs[11] = '{10'd175,  9'd389, 4'd6};
    vecs[12] = '{10'd275,  9'd390, 4'd15};
    vecs[13] = '{10'd0,    9'd0,   4'd15};
    vecs[14] = '{10'd1023, 9'd511, 4'd15};
    vecs[15] = '{10'd369,  9'd289, 4'd4};

    reset = 1'b1; posX = 10'd175; posY = 9'd95; buttons = 3'b000; click_ack = 1'b0;
    tick(2);
    chk("reset_hover", 32'(hover_cell), 32'd15);
    chk("reset_click_cell", 32'(click_cell), 32'd15);
    chk("reset_click_valid", 32'(click_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // hover table: one-cycle registered latency
    for (int i = 0; i < 16; i++) begin
      posX = vecs[i].x;
      posY = vecs[i].y;
      tick(1);
      chk($sformatf("hover_vec%0d", i), 32'(hover_cell), 32'(vecs[i].exp_cell));
    end

    // basic click in cell 0 with exact release latency; right/middle ignored
    set_pos(175, 95);
    buttons = 3'b110;
    tick(3);
    chk("side_buttons_idle", 32'(busy), 32'd0);
    buttons = 3'b001;
    tick(10);
    chk("click0_busy_held", 32'(busy), 32'd1);
    buttons = 3'b000;
    tick(2);
    chk("click0_not_yet", 32'(click_valid), 32'd0);
    tick(1);
    chk("click0_valid", 32'(click_valid), 32'd1);
    chk("click0_cell", 32'(click_cell), 32'd0);
    chk("click0_hover", 32'(hover_cell), 32'd0);
    tick(5);
    chk("click0_stable", 32'(click_cell), 32'd0);
    click_ack = 1'b1;
    tick(1);
    chk("click0_acked", 32'(click_valid), 32'd0);
    chk("click0_idle", 32'(busy), 32'd0);
    click_ack = 1'b0;

    // press in cell 4, drag to cell 5, release: no click
    set_pos(275, 195);
    tick(2);
    buttons = 3'b001;
    tick(4);
    chk("drag_press_busy", 32'(busy), 32'd1);
    set_pos(375, 195);
    tick(4);
    chk("drag_abort_busy", 32'(busy), 32'd1);
    buttons = 3'b000;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      saw_valid |= click_valid;
    end
    chk("drag_no_click", 32'(saw_valid), 32'd0);
    chk("drag_idle", 32'(busy), 32'd0);

    // hold past HOLD_MAX=16 in cell 2: timeout, no click, busy until release
    set_pos(375, 95);
    tick(2);
    buttons = 3'b001;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      saw_valid |= click_valid;
    end
    chk("timeout_busy", 32'(busy), 32'd1);
    buttons = 3'b000;
    tick(2);
    chk("timeout_busy_until_release", 32'(busy), 32'd1);
    tick(1);
    chk("timeout_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      saw_valid |= click_valid;
    end
    chk("timeout_no_click", 32'(saw_valid), 32'd0);

    // press outside the board: aborted, no click
    set_pos(100, 50);
    tick(2);
    buttons = 3'b001;
    tick(3);
    chk("outside_busy", 32'(busy), 32'd1);
    buttons = 3'b000;
    tick(4);
    chk("outside_no_click", 32'(click_valid), 32'd0);
    chk("outside_idle", 32'(busy), 32'd0);

    // PEND for cell 5, presses in cell 7 while unacknowledged
    set_pos(375, 195);
    tick(2);
    press_release(4);
    chk("pend5_valid", 32'(click_valid), 32'd1);
    chk("pend5_cell", 32'(click_cell), 32'd5);
    set_pos(275, 295);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      buttons = ((i % 10) < 5) ? 3'b001 : 3'b000;
      if (i >= 45) buttons = 3'b001;
      tick(1);
      if (click_valid !== 1'b1 || click_cell !== 4'd5) bad = 1'b1;
    end
    chk("pend5_stable_50", 32'(bad), 32'd0);
    chk("pend_hover7", 32'(hover_cell), 32'd7);
    click_ack = 1'b1;
    tick(1);
    click_ack = 1'b0;
    chk("pend5_acked", 32'(click_valid), 32'd0);
    saw_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      saw_valid |= click_valid;
      bad |= busy;
    end
    chk("held_button_not_carried", 32'(bad), 32'd0);
    buttons = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      saw_valid |= click_valid;
    end
    chk("no_click_cell7", 32'(saw_valid), 32'd0);

    // ack outside PEND ignored: click still forms with ack high during press
    set_pos(275, 195);
    tick(2);
    click_ack = 1'b1;
    buttons = 3'b001;
    tick(5);
    click_ack = 1'b0;
    buttons = 3'b000;
    tick(3);
    chk("ack_outside_pend_valid", 32'(click_valid), 32'd1);
    chk("ack_outside_pend_cell", 32'(click_cell), 32'd4);

    // reset while in PEND with the button held through reset
    buttons = 3'b001;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("pend_reset_valid", 32'(click_valid), 32'd0);
    chk("pend_reset_hover", 32'(hover_cell), 32'd15);
    chk("pend_reset_click_cell", 32'(click_cell), 32'd15);
    chk("pend_reset_busy", 32'(busy), 32'd0);
    tick(3);
    chk("post_reset_press_busy", 32'(busy), 32'd1);
    buttons = 3'b000;
    tick(3);
    chk("post_reset_click_valid", 32'(click_valid), 32'd1);
    chk("post_reset_click_cell", 32'(click_cell), 32'd4);
    click_ack = 1'b1;
    tick(1);
    click_ack = 1'b0;
    chk("post_reset_acked", 32'(click_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mouse_cell_selector.md
MOUSE_CELL_SELECTOR -- requirements
Module: mouse_cell_selector

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning), one per line:
- BOARD_X0, 170, left pixel of the 3x3 board.
- BOARD_Y0, 90, top pixel of the board.
- CELL_W, 100, cell width in pixels.
- CELL_H, 100, cell height in pixels.
- HOLD_MAX, 50_000_000, maximum press duration in clk cycles.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- posX, input, 10, mouse cursor X in pixels.
- posY, input, 9, mouse cursor Y in pixels.
- buttons, input, 3, mouse buttons: [0] left, [1] right, [2] middle.
- click_ack, input, 1, consumer accepts the pending click.
- hover_cell, output, 4, cell under the cursor, 0-8, or 15 = none.
- click_cell, output, 4, cell of the pending click, 0-8, or 15 when none is pending.
- click_valid, output, 1, a click is pending.
- busy, output, 1, FSM is not in IDLE.

REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-004 Cell mapping:
- col = 0/1/2 for posX in [X0, X0+W), [X0+W, X0+2W), [X0+2W, X0+3W).
- row uses the same rule on posY with Y0 and H.
- Intervals include the low edge and exclude the high edge.
- Mapping SHALL use comparators only (no divider), with comparisons in at least 11-bit unsigned arithmetic so no bound wraps.
REQ-005 hover_cell SHALL equal row*3+col when both coordinates are in range, else 15; it SHALL be registered, with 1-cycle latency from posX/posY.
REQ-006 buttons[0] SHALL be registered once (left_q); press = left_q rising, release = left_q falling; buttons[2:1] SHALL be ignored.
REQ-007 FSM states SHALL be IDLE, PRESS, ABORT and PEND.
REQ-008 IDLE:
- press with hover_cell != 15: latch press_cell = hover_cell, clear the hold counter, go to PRESS.
- press with hover_cell == 15: go to ABORT.
REQ-009 PRESS:
- Priority order is release, then timeout, then cell change.
- Release with hover_cell == press_cell: go to PEND.
- Release otherwise: go to IDLE.
- Hold counter reaching HOLD_MAX-1: go to ABORT.
- hover_cell != press_cell while still held: go to ABORT.
REQ-010 ABORT SHALL go to IDLE on release and emit no click.
REQ-011 PEND:
- click_valid=1 and click_cell=press_cell, both held stable until click_ack is sampled high.
- Then go to IDLE the next cycle.
- Presses during PEND are ignored, and the button-down state is not carried into IDLE: a new press requires a fresh rising edge after IDLE is entered.
REQ-012 click_ack outside PEND SHALL have no effect.
REQ-013 The hold counter SHALL be 26 bits or wider, SHALL count only in PRESS, and SHALL saturate (never wrap).
REQ-014 Minimum press-to-click_valid latency SHALL be 3 cycles after the button input is released:
- 1 cycle for the button register,
- 1 cycle for the edge compare,
- 1 cycle for the state register output.
REQ-015 busy SHALL be 1 in PRESS, ABORT and PEND.

Reset
REQ-016 On reset: state=IDLE, hover_cell=15, click_cell=15, click_valid=0, busy=0, left_q=0, hold counter=0, press_cell=15.
REQ-017 A reset asserted mid-press or while in PEND SHALL drop any pending click with no click_valid pulse. If buttons[0] is still high after reset, this SHALL count as a rising edge only via left_q going 0->1.

Verification
REQ-018 posX=175, posY=95: hold left 10 cycles, release, keep the cursor still -> hover_cell=0; click_valid=1 with click_cell=0 until click_ack, then 0.
REQ-019 Boundary positions:
- posX=469, posY=389 -> hover_cell=8.
- posX=470 -> hover_cell=15.
- posX=270, posY=90 -> hover_cell=1.
REQ-020 Press at (275,195), which is cell 4, then drag to (375,195), then release -> ABORT then IDLE; click_valid never asserts.
REQ-021 With HOLD_MAX=16, hold left for 20 cycles in cell 2, then release -> no click; busy=1 until release, then 0.
REQ-022 Reach PEND for cell 5, hold click_ack=0 for 50 cycles while pressing in cell 7 -> click_cell stays 5. Then assert click_ack -> IDLE; no click is generated for cell 7.
REQ-023 Assert reset for 1 cycle while in PEND -> click_valid=0 and hover_cell=15 on the next cycle.
